decode_buffer: RTL and testbench

- Parametrised fetch-to-decode stage: a DEPTH-entry FIFO of raw 32-bit instructions with their PCs, plus valid/ready handshakes on both sides.
- The head entry is decoded by one instance of instruction_decoder, so the execute side sees a decoded instruction::t.
- Adds flush, illegal-opcode tagging and a saturating illegal counter, none of which the plain decoder has.
- Sits between instruction fetch and execute.

---
 rtl/decode_buffer_pkg.sv | 23 ++
 rtl/instruction.sv | 26 ++
 rtl/instruction_decoder.sv | 33 +++
 rtl/decode_buffer.sv | 113 +++++++++++
 tb/tb_decode_buffer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_buffer_pkg.sv
// Constants and helpers for the fetch-to-decode buffer.
package decode_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned NUM_LEGAL_OPCODES = 11;

  localparam logic [6:0] LEGAL_OPCODES [NUM_LEGAL_OPCODES] = '{
    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
    7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011
  };

  // Flags words that are compressed/reserved or whose major opcode is outside RV32I.
  function automatic logic is_illegal(input logic [31:0] word);
    logic legal;
    legal = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_OPCODES; i++) begin
      if (word[6:0] == LEGAL_OPCODES[i]) legal = 1'b1;
    end
    return (word[1:0] != 2'b11) || !legal;
  endfunction

endpackage

// File: rtl/instruction.sv
// RV32I instruction field layout and opcode constants shared by decode logic.
package instruction;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } t;

endpackage

// File: rtl/instruction_decoder.sv
// Combinational RV32I field extraction and immediate generation.
module instruction_decoder (
  input  logic [31:0]   instr_i,
  output instruction::t decoded_o
);
  import instruction::*;

  logic [31:0] imm;

  always_comb begin
    imm = 32'h0;
    unique case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: imm = {instr_i[31:12], 12'h000};
      OPC_JAL:            imm = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                                 instr_i[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM:
                          imm = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:          imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:         imm = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                                 instr_i[11:8], 1'b0};
      default:            imm = 32'h0;
    endcase
  end

  assign decoded_o = '{opcode: instr_i[6:0],
                       rd:     instr_i[11:7],
                       funct3: instr_i[14:12],
                       rs1:    instr_i[19:15],
                       rs2:    instr_i[24:20],
                       funct7: instr_i[31:25],
                       imm:    imm};

endmodule

// File: rtl/decode_buffer.sv
// Fetch-to-decode FIFO with illegal-opcode tagging, flush and a saturating
// count of illegal instructions handed to execute.
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned PC_WIDTH      = 32,
  parameter int unsigned ILL_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instruction,
  input  logic [PC_WIDTH-1:0]           in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output instruction::t                 instruction_out,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic                          out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]    count_out,
  output logic [ILL_CNT_WIDTH-1:0]      illegal_count_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  // Entry layout lives here because its width follows PC_WIDTH.
  typedef struct packed {
    logic [31:0]         raw;
    logic [PC_WIDTH-1:0] pc;
    logic                illegal;
  } entry_t;

  localparam entry_t NOP_ENTRY = '{raw: NOP_INSTR, pc: '0, illegal: 1'b0};

  entry_t                   mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [ILL_CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;

  entry_t head_raw;
  entry_t head;
  entry_t push_entry;
  logic   push;
  logic   pop;

  assign out_valid  = (count_q != '0);
  assign in_ready   = !flush_in && ((count_q < CNT_W'(DEPTH)) || out_ready);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign push_entry = '{raw: in_instruction, pc: in_pc, illegal: is_illegal(in_instruction)};

  // Head is masked to a NOP while empty so stale storage never leaks out.
  assign head_raw = mem_q[rd_ptr_q];
  assign head     = out_valid ? head_raw : NOP_ENTRY;

  assign out_pc            = head.pc;
  assign out_illegal       = head.illegal;
  assign count_out         = count_q;
  assign illegal_count_out = ill_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (head.illegal && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + ILL_CNT_WIDTH'(1);
      end
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Storage; push is already suppressed during flush via in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= NOP_ENTRY;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  instruction_decoder u_decoder (
    .instr_i   (head.raw),
    .decoded_o (instruction_out)
  );

endmodule

// File: tb/tb_decode_buffer.sv
// Directed self-checking bench for decode_buffer with default parameters.
module tb_decode_buffer;

  logic                 clk;
  logic                 rst_n;
  logic                 flush_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instruction;
  logic [31:0]          in_pc;
  logic                 out_valid;
  logic                 out_ready;
  instruction::t        instruction_out;
  logic [31:0]          out_pc;
  logic                 out_illegal;
  logic [2:0]           count_out;
  logic [15:0]          illegal_count_out;

  int checks;
  int errors;

  localparam instruction::t NOP_DEC  = '{opcode: 7'h13, rd: 5'd0, funct3: 3'd0, rs1: 5'd0,
                                         rs2: 5'd0, funct7: 7'd0, imm: 32'd0};
  localparam instruction::t ADDI_DEC = '{opcode: 7'h13, rd: 5'd1, funct3: 3'd0, rs1: 5'd0,
                                         rs2: 5'd5, funct7: 7'd0, imm: 32'd5};
  localparam logic [31:0] ADDI = 32'h0050_0093;

  decode_buffer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_in          (flush_in),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instruction    (in_instruction),
    .in_pc             (in_pc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .instruction_out   (instruction_out),
    .out_pc            (out_pc),
    .out_illegal       (out_illegal),
    .count_out         (count_out),
    .illegal_count_out (illegal_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_instruction = w; in_pc = pc;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = 32'h0; in_pc = 32'h0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    checks++; if (instruction_out !== NOP_DEC) begin errors++; $display("FAIL reset_instr: got %h want %h", instruction_out, NOP_DEC); end
    checks++; if (illegal_count_out !== 16'h0) begin errors++; $display("FAIL reset_ill_cnt: got %h want 0", illegal_count_out); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_out_illegal: got %b want 0", out_illegal); end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(ADDI, 32'(4 * i));
      checks++; if (count_out !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_out, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    checks++; if (instruction_out !== ADDI_DEC) begin errors++; $display("FAIL full_head_decode: got %h want %h", instruction_out, ADDI_DEC); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL addi_legal: got %b want 0", out_illegal); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * i)) begin errors++; $display("FAIL drain_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 4 * i); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    checks++; if (count_out !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drained: got count=%0d v=%b want 0 0", count_out, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] next_push;
    logic [31:0] next_pop;
    out_ready = 1'b0;
    next_push = 32'h100;
    next_pop  = 32'h100;
    for (int i = 0; i < 4; i++) begin
      push_one(ADDI, next_push);
      next_push += 32'h4;
    end
    in_valid = 1'b1; out_ready = 1'b1; in_instruction = ADDI;
    for (int i = 0; i < 10; i++) begin
      in_pc = next_push;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      checks++; if (out_pc !== next_pop) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, next_pop); end
      tick();
      next_push += 32'h4;
      next_pop  += 32'h4;
      checks++; if (count_out !== 3'd4) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 4", i, count_out); end
    end
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pc !== next_pop) begin errors++; $display("FAIL stream_drain_pc[%0d]: got %h want %h", i, out_pc, next_pop); end
      tick();
      next_pop += 32'h4;
    end
    out_ready = 1'b0;
    #1;
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL stream_empty: got %0d want 0", count_out); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    push_one(32'h0000_0000, 32'h200);
    push_one(32'h0000_007F, 32'h204);
    push_one(32'h0000_0073, 32'h208);
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_low_bits: got %b want 1", out_illegal); end
    out_ready = 1'b1;
    tick();
    checks++; if (illegal_count_out !== 16'd1) begin errors++; $display("FAIL ill_cnt_1: got %0d want 1", illegal_count_out); end
    checks++; if (out_illegal !== 1'b1 || out_pc !== 32'h204) begin errors++; $display("FAIL ill_opcode: got ill=%b pc=%h want 1 204", out_illegal, out_pc); end
    tick();
    checks++; if (illegal_count_out !== 16'd2) begin errors++; $display("FAIL ill_cnt_2: got %0d want 2", illegal_count_out); end
    checks++; if (out_illegal !== 1'b0 || out_pc !== 32'h208) begin errors++; $display("FAIL ecall_legal: got ill=%b pc=%h want 0 208", out_illegal, out_pc); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (illegal_count_out !== 16'd2 || count_out !== 3'd0) begin errors++; $display("FAIL ill_after_legal: got cnt=%0d occ=%0d want 2 0", illegal_count_out, count_out); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push_one(32'h0000_0000, 32'h400);
    push_one(ADDI, 32'h404);
    push_one(ADDI, 32'h408);
    checks++; if (count_out !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count_out); end
    flush_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instruction = ADDI; in_pc = 32'h40C;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++; if (count_out !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got count=%0d v=%b want 0 0", count_out, out_valid); end
    checks++; if (illegal_count_out !== 16'd2) begin errors++; $display("FAIL flush_ill_cnt: got %0d want 2", illegal_count_out); end
    push_one(ADDI, 32'h500);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h500 || count_out !== 3'd1) begin errors++; $display("FAIL post_flush_push: got v=%b pc=%h occ=%0d want 1 500 1", out_valid, out_pc, count_out); end
  endtask

  task automatic test_reset_mid();
    push_one(ADDI, 32'h504);
    in_valid = 1'b1; in_instruction = ADDI; in_pc = 32'h508; rst_n = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count_out !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_empty: got count=%0d v=%b want 0 0", count_out, out_valid); end
    checks++; if (illegal_count_out !== 16'd0) begin errors++; $display("FAIL midrst_ill_cnt: got %0d want 0", illegal_count_out); end
    checks++; if (out_pc !== 32'h0 || instruction_out !== NOP_DEC) begin errors++; $display("FAIL midrst_head: got pc=%h ins=%h want 0 %h", out_pc, instruction_out, NOP_DEC); end
    rst_n = 1'b1;
    in_valid = 1'b1; in_pc = 32'h600;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h600) begin errors++; $display("FAIL midrst_latency: got v=%b pc=%h want 1 600", out_valid, out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
  endtask

  task automatic test_saturation();
    int total;
    total = 65536 + 3;
    in_instruction = 32'h0000_007F;
    push_one(32'h0000_007F, 32'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= total; i++) begin
      if (i == total) in_valid = 1'b0;
      tick();
      if (i == 65534) begin
        checks++; if (illegal_count_out !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", illegal_count_out); end
      end
    end
    out_ready = 1'b0;
    #1;
    checks++; if (illegal_count_out !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", illegal_count_out); end
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL sat_drained: got %0d want 0", count_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
